tuart_cmd_rx: RTL and testbench

Parametrised SUMP command receiver: next-generation Tiny-UART RX for the LogIP host link. It adds configurable bit timing, 3-sample majority voting, optional parity, 1/2 stop bits, framing/parity error reporting and an inter-word timeout. It sits between the host `rx_i` pin and the LogIP core command decoder. It delivers complete short (1-word) or long (CMD_WORDS-word) commands with a one-cycle strobe.

---
 rtl/tuart_cmd_rx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_tuart_cmd_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tuart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tuart_cmd_rx
//  Purpose  : SUMP command receiver for the LogIP host link. Receives UART
//             words with 3-sample majority voting, optional parity and 1/2
//             stop bits. It assembles short (1-word) or long (CMD_WORDS-word)
//             commands and presents each one with a one-cycle strobe.
//  Ports    : clk_i        - system clock (single domain)
//             rst_in       - synchronous reset, active low
//             rx_i         - asynchronous UART line, idle high
//             data_o       - last complete command, word k at [k*WB +: WB]
//             stb_o        - one-cycle pulse, data_o valid
//             frame_err_o  - one-cycle pulse, stop bit sampled low
//             parity_err_o - one-cycle pulse, parity mismatch
//             timeout_o    - one-cycle pulse, partial command discarded
//  Revision : 1.0 - initial release
// ============================================================================
module tuart_cmd_rx #(
  parameter int WORD_BITS    = 8,
  parameter int CMD_WORDS    = 5,
  parameter int CLK_PER_BIT  = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int TIMEOUT_CLKS = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_in,
  input  logic                           rx_i,
  output logic [WORD_BITS*CMD_WORDS-1:0] data_o,
  output logic                           stb_o,
  output logic                           frame_err_o,
  output logic                           parity_err_o,
  output logic                           timeout_o
);

  localparam int c_DW    = WORD_BITS * CMD_WORDS;
  localparam int c_ASM_W = WORD_BITS * (CMD_WORDS - 1);
  localparam int c_CNT_W = $clog2(CLK_PER_BIT);
  localparam int c_BIT_W = $clog2(WORD_BITS + 1);
  localparam int c_WC_W  = $clog2(CMD_WORDS + 1);
  localparam int c_MID   = CLK_PER_BIT / 2;

  localparam logic [c_CNT_W-1:0] c_SMP0 = c_CNT_W'(c_MID - 1);
  localparam logic [c_CNT_W-1:0] c_SMP1 = c_CNT_W'(c_MID);
  localparam logic [c_CNT_W-1:0] c_DEC  = c_CNT_W'(c_MID + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLK_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0] c_NBIT = c_BIT_W'(WORD_BITS);
  localparam logic [c_WC_W-1:0]  c_WC_1 = c_WC_W'(1);
  localparam logic [c_WC_W-1:0]  c_WC_N = c_WC_W'(CMD_WORDS);
  localparam logic               c_ODD  = (PARITY_ODD != 0);
  localparam logic               c_STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;
  localparam logic [2:0] c_BREAK  = 3'd5;

  logic               r_sync1;
  logic               r_rxs;
  logic [2:0]         r_state;
  logic [2:0]         w_nstate;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_s0;
  logic               r_s1;
  logic [c_BIT_W-1:0] r_bitn;
  logic               r_stopn;
  logic               r_bad;
  logic [WORD_BITS-1:0] r_shift;
  logic [c_ASM_W-1:0] r_asm;
  logic [c_WC_W-1:0]  r_wc;
  logic [c_DW-1:0]    r_data;
  logic               r_stb;
  logic               r_ferr;
  logic               r_perr;
  logic               r_tout;

  logic               w_dec;
  logic               w_bend;
  logic               w_maj;
  logic               w_ferr;
  logic               w_perr;
  logic               w_commit;
  logic               w_short;
  logic               w_long;
  logic               w_tout;
  logic [c_WC_W-1:0]  w_wc_inc;
  logic [c_DW-1:0]    w_full;

  assign w_dec  = (r_cnt == c_DEC);
  assign w_bend = (r_cnt == c_LAST);
  // Two stored samples plus the live one give the 3-sample vote at MID+1.
  assign w_maj  = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      c_IDLE: begin
        if (!r_rxs) w_nstate = c_START;
      end
      c_START: begin
        if (w_dec && w_maj)  w_nstate = c_IDLE;
        else if (w_bend)     w_nstate = c_DATA;
      end
      c_DATA: begin
        if (w_bend && (r_bitn == c_NBIT))
          w_nstate = (PARITY_EN != 0) ? c_PARITY : c_STOP;
      end
      c_PARITY: begin
        // Good or bad parity alike moves on to the stop bit(s) to resync.
        if (w_bend) w_nstate = c_STOP;
      end
      c_STOP: begin
        // Leave at the decision point so a start bit right after the
        // stop bit is never missed.
        if (w_dec) begin
          if (!w_maj)                       w_nstate = c_BREAK;
          else if (r_stopn == c_STOP_LAST)  w_nstate = c_IDLE;
        end
      end
      c_BREAK: begin
        if (r_rxs) w_nstate = c_IDLE;
      end
      default: w_nstate = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / event decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_ferr   = (r_state == c_STOP) && w_dec && !w_maj;
    w_perr   = (r_state == c_PARITY) && w_dec && (((^r_shift) ^ w_maj) != c_ODD);
    // A word whose parity already failed is dropped rather than committed.
    w_commit = (r_state == c_STOP) && w_dec && w_maj &&
               (r_stopn == c_STOP_LAST) && !r_bad;
    w_wc_inc = r_wc + 1'b1;
    w_short  = w_commit && (w_wc_inc == c_WC_1) && !r_shift[WORD_BITS-1];
    w_long   = w_commit && (w_wc_inc == c_WC_N);
    w_full   = {r_shift, r_asm};
  end

  // --------------------------------------------------------------------------
  // Synchronizer, bit timing and word assembly
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_cnt   <= '0;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
      r_bitn  <= '0;
      r_stopn <= 1'b0;
      r_bad   <= 1'b0;
      r_shift <= '0;
      r_asm   <= '0;
      r_wc    <= '0;
      r_data  <= '0;
      r_stb   <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      r_sync1 <= rx_i;
      r_rxs   <= r_sync1;

      // Counter is parked at 0 while waiting so START begins at count 0.
      if ((r_state == c_IDLE) || (r_state == c_BREAK) || w_bend) r_cnt <= '0;
      else                                                        r_cnt <= r_cnt + 1'b1;

      if (r_cnt == c_SMP0) r_s0 <= r_rxs;
      if (r_cnt == c_SMP1) r_s1 <= r_rxs;

      if (r_state != c_DATA)  r_bitn <= '0;
      else if (w_dec)         r_bitn <= r_bitn + 1'b1;

      if (r_state != c_STOP)      r_stopn <= 1'b0;
      else if (w_dec && w_maj)    r_stopn <= 1'b1;

      if (r_state == c_IDLE)  r_bad <= 1'b0;
      else if (w_perr)        r_bad <= 1'b1;

      // Any event that ends or aborts a command empties the assembly.
      if (w_perr || w_ferr || w_tout || w_short || w_long) begin
        r_wc    <= '0;
        r_asm   <= '0;
        r_shift <= '0;
      end else if (w_commit) begin
        r_asm[r_wc*WORD_BITS +: WORD_BITS] <= r_shift;
        r_wc <= w_wc_inc;
      end else if ((r_state == c_DATA) && w_dec) begin
        r_shift <= {w_maj, r_shift[WORD_BITS-1:1]};
      end

      if (w_short) begin
        r_data                <= '0;
        r_data[WORD_BITS-1:0] <= r_shift;
      end else if (w_long) begin
        r_data <= w_full;
      end

      r_stb  <= w_short | w_long;
      r_ferr <= w_ferr;
      r_perr <= w_perr;
      r_tout <= w_tout;
    end
  end

  // --------------------------------------------------------------------------
  // Inter-word timeout (only built when enabled)
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT_CLKS > 0) begin : g_timeout
      localparam int c_TO_W = $clog2(TIMEOUT_CLKS + 1);
      localparam logic [c_TO_W-1:0] c_TO_HIT = c_TO_W'(TIMEOUT_CLKS - 1);
      logic [c_TO_W-1:0] r_idle;
      logic              w_run;

      // Counting only while idle and high: a start edge stops and clears it.
      assign w_run  = (r_state == c_IDLE) && (r_wc != '0) && r_rxs;
      assign w_tout = w_run && (r_idle == c_TO_HIT);

      always_ff @(posedge clk_i) begin
        if (!rst_in) begin
          r_idle <= '0;
        end else if (w_run && !w_tout) begin
          r_idle <= r_idle + 1'b1;
        end else begin
          r_idle <= '0;
        end
      end
    end else begin : g_no_timeout
      assign w_tout = 1'b0;
    end
  endgenerate

  assign data_o       = r_data;
  assign stb_o        = r_stb;
  assign frame_err_o  = r_ferr;
  assign parity_err_o = r_perr;
  assign timeout_o    = r_tout;

endmodule
`default_nettype wire

// File: tb/tb_tuart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tuart_cmd_rx
//  Purpose  : Directed self-checking bench for tuart_cmd_rx. Three instances:
//             defaults, even parity enabled, and a 1000-clock timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tuart_cmd_rx;

  localparam int c_CPB = 16;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rx_line;
  logic [39:0] data_q [3];
  logic        stb    [3];
  logic        ferr   [3];
  logic        perr   [3];
  logic        tout   [3];

  int n_stb  [3];
  int n_ferr [3];
  int n_perr [3];
  int n_tout [3];

  int n_vec;
  int n_err;

  tuart_cmd_rx u_def (
    .clk_i(clk), .rst_in(rst_n), .rx_i(rx_line[0]),
    .data_o(data_q[0]), .stb_o(stb[0]), .frame_err_o(ferr[0]),
    .parity_err_o(perr[0]), .timeout_o(tout[0])
  );

  tuart_cmd_rx #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk_i(clk), .rst_in(rst_n), .rx_i(rx_line[1]),
    .data_o(data_q[1]), .stb_o(stb[1]), .frame_err_o(ferr[1]),
    .parity_err_o(perr[1]), .timeout_o(tout[1])
  );

  tuart_cmd_rx #(.TIMEOUT_CLKS(1000)) u_to (
    .clk_i(clk), .rst_in(rst_n), .rx_i(rx_line[2]),
    .data_o(data_q[2]), .stb_o(stb[2]), .frame_err_o(ferr[2]),
    .parity_err_o(perr[2]), .timeout_o(tout[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (stb[k])  n_stb[k]++;
        if (ferr[k]) n_ferr[k]++;
        if (perr[k]) n_perr[k]++;
        if (tout[k]) n_tout[k]++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input int sel, input logic v);
    @(negedge clk);
    rx_line[sel] = v;
    repeat (c_CPB - 1) @(negedge clk);
  endtask

  task automatic send_word(input int sel, input logic [7:0] d,
                           input logic has_par, input logic par, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (has_par) drive_bit(sel, par);
    drive_bit(sel, stop);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int k = 0; k < 3; k++) begin
      n_stb[k] = 0; n_ferr[k] = 0; n_perr[k] = 0; n_tout[k] = 0;
    end
    rx_line = 3'b111;
    rst_n   = 1'b0;
    idle(5);

    // Reset state
    check("rst_data",  data_q[0], 64'h0);
    check("rst_stb",   stb[0],    64'h0);
    check("rst_ferr",  ferr[0],   64'h0);
    check("rst_perr",  perr[0],   64'h0);
    check("rst_tout",  tout[0],   64'h0);
    check("rst_data_par", data_q[1], 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    // Short command 0x01
    send_word(0, 8'h01, 1'b0, 1'b0, 1'b1);
    idle(20);
    check("short_stb_cnt", n_stb[0],  64'd1);
    check("short_data",    data_q[0], 64'h01);
    check("short_ferr",    n_ferr[0], 64'd0);
    check("short_perr",    n_perr[0], 64'd0);

    // Long command, back-to-back words
    send_word(0, 8'hC0, 1'b0, 1'b0, 1'b1);
    send_word(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_word(0, 8'h22, 1'b0, 1'b0, 1'b1);
    send_word(0, 8'h33, 1'b0, 1'b0, 1'b1);
    check("long_partial_stb",  n_stb[0],  64'd1);
    check("long_partial_hold", data_q[0], 64'h01);
    send_word(0, 8'h44, 1'b0, 1'b0, 1'b1);
    idle(20);
    check("long_stb_cnt", n_stb[0],  64'd2);
    check("long_data",    data_q[0], 64'h44_3322_11C0);

    // 3-clock glitch rejected at START
    @(negedge clk);
    rx_line[0] = 1'b0;
    idle(3);
    rx_line[0] = 1'b1;
    idle(40);
    check("glitch_stb",  n_stb[0],  64'd2);
    check("glitch_ferr", n_ferr[0], 64'd0);
    check("glitch_perr", n_perr[0], 64'd0);
    send_word(0, 8'h02, 1'b0, 1'b0, 1'b1);
    idle(20);
    check("post_glitch_stb",  n_stb[0],  64'd3);
    check("post_glitch_data", data_q[0], 64'h02);

    // Framing error, line held low, then recovery
    send_word(0, 8'hC0, 1'b0, 1'b0, 1'b0);
    idle(40);
    rx_line[0] = 1'b1;
    idle(20);
    check("ferr_cnt",   n_ferr[0], 64'd1);
    check("ferr_nostb", n_stb[0],  64'd3);
    send_word(0, 8'h05, 1'b0, 1'b0, 1'b1);
    idle(20);
    check("ferr_rec_stb",  n_stb[0],  64'd4);
    check("ferr_rec_data", data_q[0], 64'h05);
    check("def_tout",      n_tout[0], 64'd0);

    // Even parity: bad then good
    send_word(1, 8'h03, 1'b1, 1'b1, 1'b1);
    idle(20);
    check("par_err_cnt", n_perr[1], 64'd1);
    check("par_err_stb", n_stb[1],  64'd0);
    check("par_err_fe",  n_ferr[1], 64'd0);
    send_word(1, 8'h03, 1'b1, 1'b0, 1'b1);
    idle(20);
    check("par_ok_stb",  n_stb[1],  64'd1);
    check("par_ok_data", data_q[1], 64'h03);
    check("par_ok_perr", n_perr[1], 64'd1);

    // Timeout of a partial long command
    send_word(2, 8'h07, 1'b0, 1'b0, 1'b1);
    idle(20);
    check("to_pre_data", data_q[2], 64'h07);
    send_word(2, 8'hC0, 1'b0, 1'b0, 1'b1);
    send_word(2, 8'h11, 1'b0, 1'b0, 1'b1);
    idle(900);
    check("to_early", n_tout[2], 64'd0);
    idle(200);
    check("to_cnt",  n_tout[2], 64'd1);
    check("to_stb",  n_stb[2],  64'd1);
    check("to_hold", data_q[2], 64'h07);
    send_word(2, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(20);
    check("to_after_stb",  n_stb[2],  64'd2);
    check("to_after_data", data_q[2], 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
